core_exerciser: RTL and testbench

- Parametrised on-chip exerciser for long-latency crypto cores (X25519 scalar mult, field multipliers).
- A debug-probe toggle launches a configurable number of back-to-back core operations, optionally chaining each result into the next operand.
- Captures the final result, per-operation latency and total cycle count for readback over the same probe.
- Sits between a VIO-style debug core and the DUT in area/timing bring-up builds.

---
 rtl/core_exerciser_if.sv | 25 ++
 rtl/core_exerciser.sv | 185 ++++++++++++++++++
 tb/tb_core_exerciser.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_exerciser_if.sv
// Exerciser <-> crypto core handshake bundle.
//   core_en     : one-cycle launch strobe (exerciser -> core)
//   core_a/b    : operands, held from launch until the matching core_valid
//   core_valid  : result strobe (core -> exerciser)
//   core_result : result, meaningful while core_valid=1
// master modport is the exerciser side, slave modport is the core side.
interface core_exerciser_if #(
  parameter int unsigned DATA_WIDTH = 256
);
  logic                  core_en;
  logic [DATA_WIDTH-1:0] core_a;
  logic [DATA_WIDTH-1:0] core_b;
  logic                  core_valid;
  logic [DATA_WIDTH-1:0] core_result;

  modport master (
    output core_en, core_a, core_b,
    input  core_valid, core_result
  );

  modport slave (
    input  core_en, core_a, core_b,
    output core_valid, core_result
  );
endinterface

// File: rtl/core_exerciser.sv
// On-chip exerciser for long-latency crypto cores. A level change on
// start_toggle launches cfg_iterations (0 treated as 1) back-to-back core
// operations, optionally feeding each result back as the next operand A, and
// captures the final result, per-operation latency and total run cycles.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_toggle    : any level change requests a run (ignored while busy)
//   cfg_iterations  : operations per run
//   cfg_chain       : 1 = operand A of op n+1 is the result of op n
//   operand_a/b     : run operands, latched at run start
//   core            : core handshake (core_exerciser_if.master)
//   busy            : run in progress
//   result_valid    : final result available (level)
//   result          : last captured core_result
//   iter_done       : operations completed in current/last run
//   last_latency    : launch-to-valid latency of the latest operation
//   total_cycles    : cycles from first launch to final valid (saturating)
//   timeout_err     : run aborted by the per-operation watchdog
//
// Optional feature: define CORE_EXERCISER_TIMEOUT_EN to enable the watchdog
// (TIMEOUT_CYCLES, truncated to CYCLE_WIDTH). Without it timeout_err stays 0.
module core_exerciser #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned ITER_WIDTH     = 16,
  parameter int unsigned CYCLE_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_toggle,
  input  logic [ITER_WIDTH-1:0]  cfg_iterations,
  input  logic                   cfg_chain,
  input  logic [DATA_WIDTH-1:0]  operand_a,
  input  logic [DATA_WIDTH-1:0]  operand_b,
  core_exerciser_if.master       core,
  output logic                   busy,
  output logic                   result_valid,
  output logic [DATA_WIDTH-1:0]  result,
  output logic [ITER_WIDTH-1:0]  iter_done,
  output logic [CYCLE_WIDTH-1:0] last_latency,
  output logic [CYCLE_WIDTH-1:0] total_cycles,
  output logic                   timeout_err
);

`ifdef CORE_EXERCISER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LIM = CYCLE_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   toggle_q;
  logic                   chain_q;
  logic [ITER_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic                   en_q;
  logic                   busy_q;
  logic                   result_valid_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic [ITER_WIDTH-1:0]  iter_q;
  logic [CYCLE_WIDTH-1:0] lat_q;
  logic [CYCLE_WIDTH-1:0] last_lat_q;
  logic [CYCLE_WIDTH-1:0] total_q;
  logic                   timeout_q;

  // Combinational helpers feeding the state register.
  logic                   start_edge_d;
  logic [ITER_WIDTH-1:0]  count_d;
  logic [ITER_WIDTH-1:0]  iter_inc_d;
  logic [CYCLE_WIDTH-1:0] lat_inc_d;
  logic [CYCLE_WIDTH-1:0] total_inc_d;
  logic                   timeout_hit_d;

  assign start_edge_d  = start_toggle ^ toggle_q;
  assign count_d       = (cfg_iterations == '0) ? ITER_WIDTH'(1) : cfg_iterations;
  assign iter_inc_d    = iter_q + ITER_WIDTH'(1);
  assign lat_inc_d     = (lat_q == '1) ? lat_q : lat_q + CYCLE_WIDTH'(1);
  assign total_inc_d   = (total_q == '1) ? total_q : total_q + CYCLE_WIDTH'(1);
  // Fires on the WAIT cycle that brings the operation to TIMEOUT_CYCLES.
  assign timeout_hit_d = TIMEOUT_EN && (lat_inc_d >= TIMEOUT_LIM);

  // Run sequencer: all state and outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      toggle_q       <= 1'b0;
      chain_q        <= 1'b0;
      count_q        <= '0;
      a_q            <= '0;
      b_q            <= '0;
      en_q           <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      iter_q         <= '0;
      lat_q          <= '0;
      last_lat_q     <= '0;
      total_q        <= '0;
      timeout_q      <= 1'b0;
    end else begin
      // Tracked in every state so edges seen while busy are simply dropped.
      toggle_q <= start_toggle;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge_d) begin
            a_q            <= operand_a;
            b_q            <= operand_b;
            chain_q        <= cfg_chain;
            count_q        <= count_d;
            result_valid_q <= 1'b0;
            iter_q         <= '0;
            total_q        <= '0;
            last_lat_q     <= '0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b1;
            en_q           <= 1'b1;
            state_q        <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          en_q    <= 1'b0;
          lat_q   <= '0;
          // The first launch is not counted; relaunch ISSUE cycles are.
          if (iter_q != '0) begin
            total_q <= total_inc_d;
          end
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          lat_q   <= lat_inc_d;
          total_q <= total_inc_d;
          if (core.core_valid) begin
            result_q   <= core.core_result;
            last_lat_q <= lat_inc_d;
            iter_q     <= iter_inc_d;
            if (iter_inc_d == count_q) begin
              busy_q         <= 1'b0;
              result_valid_q <= 1'b1;
              state_q        <= ST_DONE;
            end else begin
              en_q    <= 1'b1;
              state_q <= ST_ISSUE;
              if (chain_q) begin
                a_q <= core.core_result;
              end
            end
          end else if (timeout_hit_d) begin
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core.core_en = en_q;
  assign core.core_a  = a_q;
  assign core.core_b  = b_q;

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign iter_done    = iter_q;
  assign last_latency = last_lat_q;
  assign total_cycles = total_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_core_exerciser.sv
// Randomised self-checking bench for core_exerciser with a behavioural core
// and a transaction-level reference of each run.
module tb_core_exerciser;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 50;

  logic          clk;
  logic          rst_n;
  logic          start_toggle;
  logic [IW-1:0] cfg_iterations;
  logic          cfg_chain;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic          busy;
  logic          result_valid;
  logic [DW-1:0] result;
  logic [IW-1:0] iter_done;
  logic [CW-1:0] last_latency;
  logic [CW-1:0] total_cycles;
  logic          timeout_err;

  logic          model_valid;
  logic [DW-1:0] model_res;
  logic          stray_valid;
  logic [DW-1:0] stray_res;

  core_exerciser_if #(.DATA_WIDTH(DW)) cif ();

  assign cif.core_valid  = model_valid | stray_valid;
  assign cif.core_result = stray_valid ? stray_res : model_res;

  core_exerciser #(
    .DATA_WIDTH    (DW),
    .ITER_WIDTH    (IW),
    .CYCLE_WIDTH   (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_toggle  (start_toggle),
    .cfg_iterations(cfg_iterations),
    .cfg_chain     (cfg_chain),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .core          (cif),
    .busy          (busy),
    .result_valid  (result_valid),
    .result        (result),
    .iter_done     (iter_done),
    .last_latency  (last_latency),
    .total_cycles  (total_cycles),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: expected launches {a,b}, per-launch latencies for the core.
  logic [63:0] exp_ops[$];
  int          lat_q[$];
  int          fn_mode;
  logic [DW-1:0] fixed_res;

  // Expected values of the last planned run.
  logic [DW-1:0] e_res, e_a;
  int            e_iter, e_last, e_tot;

  // Expected idle outputs, checked every cycle while hold_chk=1.
  bit            hold_chk;
  logic [DW-1:0] h_res, h_a, h_b;
  logic          h_rv, h_to;
  int            h_iter, h_last, h_tot;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (fn_mode)
      0:       return fixed_res;
      1:       return a + DW'(1);
      default: return (a * DW'(3)) ^ b;
    endcase
  endfunction

  // Behavioural core: responds lat cycles after the launch cycle (lat 0 = never).
  initial begin : core_model
    int cnt;
    bit pend;
    logic [DW-1:0] cap_a, cap_b;
    model_valid = 1'b0;
    model_res   = '0;
    pend = 1'b0;
    cnt = 0;
    cap_a = '0;
    cap_b = '0;
    forever begin
      @(posedge clk);
      #1;
      model_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            model_valid = 1'b1;
            model_res   = core_fn(cap_a, cap_b);
            pend        = 1'b0;
          end
        end
        if (cif.core_en) begin
          int l;
          l = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
          if (l > 0) begin
            pend  = 1'b1;
            cnt   = l;
            cap_a = cif.core_a;
            cap_b = cif.core_b;
          end
        end
      end
    end
  end

  // Per-cycle compare: every launch against the reference queue, idle outputs against hold values.
  initial begin : compare
    logic en_prev;
    logic [63:0] op;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cif.core_en === 1'b1) begin
        chk("en_single_cycle", 64'(en_prev), 64'(0));
        chk("busy_at_launch", 64'(busy), 64'(1));
        if (exp_ops.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch: got core_en=1 with core_a=0x%0h, expected no launch (t=%0t)",
                   cif.core_a, $time);
        end else begin
          op = exp_ops.pop_front();
          chk("launch_core_a", 64'(cif.core_a), 64'(op[63:32]));
          chk("launch_core_b", 64'(cif.core_b), 64'(op[31:0]));
        end
      end
      if (hold_chk) begin
        chk("hold_busy",         64'(busy),         64'(0));
        chk("hold_core_en",      64'(cif.core_en),  64'(0));
        chk("hold_result_valid", 64'(result_valid), 64'(h_rv));
        chk("hold_result",       64'(result),       64'(h_res));
        chk("hold_iter_done",    64'(iter_done),    64'(h_iter));
        chk("hold_last_latency", 64'(last_latency), 64'(h_last));
        chk("hold_total_cycles", 64'(total_cycles), 64'(h_tot));
        chk("hold_timeout_err",  64'(timeout_err),  64'(h_to));
        chk("hold_core_a",       64'(cif.core_a),   64'(h_a));
        chk("hold_core_b",       64'(cif.core_b),   64'(h_b));
      end
      en_prev = cif.core_en;
    end
  end

  // Reference for one run: operand chain, final result, latency and cycle totals.
  task automatic plan_run(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit ch,
                          input int iters, input int lat_mode);
    int n, l, tot;
    logic [DW-1:0] cur, r;
    n = (iters == 0) ? 1 : iters;
    cur = a;
    r = '0;
    tot = 0;
    l = 0;
    for (int k = 0; k < n; k++) begin
      l = (lat_mode > 0) ? lat_mode : int'($urandom_range(6, 1));
      exp_ops.push_back({cur, b});
      lat_q.push_back(l);
      tot += l;
      r = core_fn(cur, b);
      e_a = cur;
      if (ch) cur = r;
    end
    e_res  = r;
    e_iter = n;
    e_last = l;
    e_tot  = tot + n - 1;
  endtask

  task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit ch, input int iters);
    bit seen;
    operand_a      = a;
    operand_b      = b;
    cfg_chain      = ch;
    cfg_iterations = IW'(iters);
    start_toggle   = ~start_toggle;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    chk("busy_rise", 64'(seen), 64'(1));
    // Inputs after the start edge must not affect the run.
    operand_a = $urandom;
    operand_b = $urandom;
    cfg_chain = $urandom_range(1, 0) != 0;
    cfg_iterations = IW'($urandom);
  endtask

  task automatic do_run(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit ch,
                        input int iters, input int lat_mode, input bit flip_mid);
    int cyc;
    @(negedge clk);
    hold_chk = 1'b0;
    plan_run(a, b, ch, iters, lat_mode);
    launch(a, b, ch, iters);
    if (flip_mid) begin
      repeat (2) @(negedge clk);
      start_toggle = ~start_toggle;
      @(negedge clk);
      start_toggle = ~start_toggle;
    end
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_ends",          64'(busy),           64'(0));
    chk("launches_missing",  64'(exp_ops.size()), 64'(0));
    chk("run_result",        64'(result),         64'(e_res));
    chk("run_result_valid",  64'(result_valid),   64'(1));
    chk("run_iter_done",     64'(iter_done),      64'(e_iter));
    chk("run_last_latency",  64'(last_latency),   64'(e_last));
    chk("run_total_cycles",  64'(total_cycles),   64'(e_tot));
    chk("run_timeout_err",   64'(timeout_err),    64'(0));
    exp_ops.delete();
    lat_q.delete();
    h_res = e_res; h_rv = 1'b1; h_iter = e_iter; h_last = e_last; h_tot = e_tot;
    h_to = 1'b0; h_a = e_a; h_b = b;
    hold_chk = 1'b1;
  endtask

  // Asynchronous reset in the middle of a run; everything returns to zero.
  task automatic reset_mid_run();
    @(negedge clk);
    hold_chk = 1'b0;
    #1;
    rst_n = 1'b0;
    start_toggle = 1'b0;
    #1;
    chk("rst_core_en",      64'(cif.core_en),   64'(0));
    chk("rst_busy",         64'(busy),          64'(0));
    chk("rst_result",       64'(result),        64'(0));
    chk("rst_total_cycles", 64'(total_cycles),  64'(0));
    chk("rst_core_a",       64'(cif.core_a),    64'(0));
    exp_ops.delete();
    lat_q.delete();
    h_res = '0; h_rv = 1'b0; h_iter = 0; h_last = 0; h_tot = 0; h_to = 1'b0; h_a = '0; h_b = '0;
    hold_chk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [DW-1:0] ra, rb;
    rst_n = 1'b0;
    start_toggle = 1'b0;
    cfg_iterations = '0;
    cfg_chain = 1'b0;
    operand_a = '0;
    operand_b = '0;
    stray_valid = 1'b0;
    stray_res = '0;
    fn_mode = 0;
    fixed_res = '0;
    hold_chk = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",         64'(busy),         64'(0));
    chk("reset_result_valid", 64'(result_valid), 64'(0));
    chk("reset_iter_done",    64'(iter_done),    64'(0));
    chk("reset_last_latency", 64'(last_latency), 64'(0));
    chk("reset_core_en",      64'(cif.core_en),  64'(0));
    rst_n = 1'b1;
    h_res = '0; h_rv = 1'b0; h_iter = 0; h_last = 0; h_tot = 0; h_to = 1'b0; h_a = '0; h_b = '0;
    hold_chk = 1'b1;
    repeat (3) @(negedge clk);

    // Single operation, fixed result, latency 3.
    fn_mode = 0;
    fixed_res = DW'(32'hABC);
    do_run(DW'(32'h09), DW'(32'h05), 1'b0, 1, 3, 1'b0);
    chk("t1_result",       64'(result),       64'(32'hABC));
    chk("t1_last_latency", 64'(last_latency), 64'(3));
    chk("t1_total_cycles", 64'(total_cycles), 64'(3));
    chk("t1_iter_done",    64'(iter_done),    64'(1));
    chk("t1_core_a",       64'(cif.core_a),   64'(32'h09));
    repeat (3) @(negedge clk);

    // Four chained increments, latency 2.
    fn_mode = 1;
    do_run(DW'(32'h10), DW'(32'h77), 1'b1, 4, 2, 1'b0);
    chk("t2_result",       64'(result),       64'(32'h14));
    chk("t2_iter_done",    64'(iter_done),    64'(4));
    chk("t2_total_cycles", 64'(total_cycles), 64'(11));
    chk("t2_core_a_last",  64'(cif.core_a),   64'(32'h13));
    repeat (3) @(negedge clk);

    // Zero iterations behaves as one.
    fn_mode = 2;
    do_run(DW'($urandom), DW'($urandom), 1'b1, 0, 4, 1'b0);
    chk("t3_iter_done", 64'(iter_done), 64'(1));
    repeat (3) @(negedge clk);

    // Start edges while busy are dropped; no extra run afterwards.
    do_run(DW'($urandom), DW'($urandom), 1'b1, 3, 5, 1'b1);
    chk("t4_iter_done", 64'(iter_done), 64'(3));
    repeat (10) @(negedge clk);

    // Random runs.
    for (int i = 0; i < 14; i++) begin
      fn_mode = int'($urandom_range(2, 1));
      do_run(DW'($urandom), DW'($urandom), $urandom_range(1, 0) != 0,
             int'($urandom_range(5, 0)), 0, 1'b0);
      repeat (int'($urandom_range(3, 1))) @(negedge clk);
    end

    // Stray core_valid while idle changes nothing.
    @(negedge clk);
    stray_res = DW'($urandom);
    stray_valid = 1'b1;
    repeat (2) @(negedge clk);
    stray_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Core that never answers.
    @(negedge clk);
    hold_chk = 1'b0;
    ra = DW'($urandom);
    rb = DW'($urandom);
    exp_ops.push_back({ra, rb});
    lat_q.push_back(0);
    launch(ra, rb, 1'b0, 1);
`ifdef CORE_EXERCISER_TIMEOUT_EN
    repeat (TO) @(negedge clk);
    chk("to_busy_before_limit", 64'(busy), 64'(1));
    @(negedge clk);
    chk("to_busy",         64'(busy),         64'(0));
    chk("to_timeout_err",  64'(timeout_err),  64'(1));
    chk("to_result_valid", 64'(result_valid), 64'(0));
    chk("to_result",       64'(result),       64'(h_res));
    chk("to_total_cycles", 64'(total_cycles), 64'(TO));
    h_rv = 1'b0; h_iter = 0; h_last = 0; h_tot = TO; h_to = 1'b1; h_a = ra; h_b = rb;
    hold_chk = 1'b1;
    repeat (2) @(negedge clk);
    stray_res = DW'($urandom);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (3) @(negedge clk);
    fn_mode = 2;
    do_run(DW'($urandom), DW'($urandom), 1'b1, 2, 0, 1'b0);
    repeat (2) @(negedge clk);
`else
    repeat (200) @(negedge clk);
    chk("nto_busy_200",        64'(busy),         64'(1));
    chk("nto_timeout_err",     64'(timeout_err),  64'(0));
    chk("nto_result_valid",    64'(result_valid), 64'(0));
    reset_mid_run();
`endif

    // Reset in the middle of a WAIT, then a clean run afterwards.
    fn_mode = 2;
    do_run(DW'($urandom), DW'($urandom), 1'b0, 1, 2, 1'b0);
    @(negedge clk);
    hold_chk = 1'b0;
    plan_run(DW'($urandom), DW'($urandom), 1'b1, 2, 20);
    launch(exp_ops[0][63:32], exp_ops[0][31:0], 1'b1, 2);
    repeat (6) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    reset_mid_run();
    do_run(DW'($urandom), DW'($urandom), 1'b1, 3, 0, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
